packet_ejector: RTL and testbench
=================================

# packet_ejector

- Traffic sink at a router's Local output port; the receive-side counterpart of the per-PE injectors.
- Accepts packets from the router over the Req/Gnt/Full handshake and buffers them in a small FIFO.
- Drains the FIFO at a programmable service rate and checks each packet's destination field.
- Publishes per-packet receive strobes plus received/misrouted counters to the traffic-generator top.

## Interface
Parameters:
- routerID, 6'b000_000, ID of the attached router (reporting only)
- dataWidth, 32, packet width
- dim, 4, bits per x/y field (1 direction + 3 position)
- FifoDepth, 4, receive buffer entries (power of two, ≥2)
- DrainPeriod, 1, minimum cycles between pops (≥1)
- ExpectDst, 8'b1001_0010, expected {xDst,yDst} for packets ejected here

Ports:
- clk, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-high
- ReqUpStr, in, 1, router request; PacketIn valid while high
- GntUpStr, out, 1, one-cycle grant pulse; packet captured
- UpStrFull, out, 1, FIFO holds FifoDepth entries
- PacketIn, in, dataWidth, {xDst,yDst,xSrc,ySrc,PacketID[9:0],ModuleID[5:0]}
- DrainEn, in, 1, consumer ready; pops allowed while high
- RxValid, out, 1, one-cycle pulse per popped packet
- RxPacket, out, dataWidth, popped packet; held until next pop
- RxError, out, 1, with RxValid: destination mismatch
- RxCount, out, 16, total popped packets
- ErrCount, out, 16, popped packets with RxError
- FifoLevel, out, $clog2(FifoDepth)+1, current occupancy

## Operation
- Reset: all outputs 0, FSM IDLE, FIFO empty, drain timer 0.
- Accept FSM (states IDLE, ACK, RELEASE):
  - IDLE: if ReqUpStr & !UpStrFull, push PacketIn, GntUpStr<=1, go ACK. Otherwise stay.
  - ACK: GntUpStr<=0. If ReqUpStr is still high, go RELEASE; else go IDLE.
  - RELEASE: wait for ReqUpStr==0, then go IDLE. This stops the stale request from being taken as a second packet.
- Drain:
  - Timer counts 0..DrainPeriod-1 and saturates at DrainPeriod-1.
  - Pop when timer==DrainPeriod-1 & DrainEn & FIFO non-empty. The pop resets the timer to 0.
  - Pop actions: RxPacket<=head, RxValid<=1, RxError<=(head[31:24]!=ExpectDst), RxCount++, ErrCount++ if error.
- Counters: 16-bit, wrap modulo 2^16. No saturation.
- Simultaneous push and pop: both occur in the same cycle. FifoLevel is unchanged. Pointers wrap modulo FifoDepth.
- UpStrFull = (FifoLevel==FifoDepth), registered with the level.
  - A push is refused when the FIFO is full at the IDLE decision, even if a pop happens in that same cycle.
  - The request is granted one cycle later.
- ReqUpStr falling before a grant: no capture, no grant, FSM stays in IDLE.
- reset asserted mid-handshake: the FSM, FIFO and counters clear immediately. A partly granted packet is lost. The bench must not count it.

## Timing
- Grant latency: ReqUpStr sampled high at edge k (not full) → GntUpStr high from edge k to edge k+1. The packet is in the FIFO after edge k.
- Minimum spacing between two grants: 3 cycles for a requester that deasserts one cycle after seeing the grant.
- Push-to-pop: a packet pushed at edge k can pop at edge k+1 at the earliest (DrainPeriod=1, DrainEn high). RxValid is high k+1..k+2.
- Full flag: updates on the edge the level changes. It is visible to the router the same cycle as GntUpStr on a filling push.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Shared package holds:
  - packet field offsets (xDst 31:28, yDst 27:24, xSrc 23:20, ySrc 19:16, PacketID 15:6, ModuleID 5:0)
  - FSM state encodings IDLE=2'b00, ACK=2'b01, RELEASE=2'b10
- One sub-module, ejector_fifo: synchronous FIFO with push, pop, level and full/empty.
- packet_ejector holds the FSM, drain timer, checker and counters.

## Test plan
- Single packet 32'h9200_0045 with DrainEn=1 → GntUpStr 1-cycle pulse one edge after ReqUpStr; RxValid at the next edge; RxPacket=32'h9200_0045, RxError=0, RxCount=1.
- Requester holds ReqUpStr two cycles after the grant → exactly one push; FSM passes through RELEASE; FifoLevel peaks at 1.
- DrainEn=0 with 5 back-to-back requests, FifoDepth=4 → 4 grants, UpStrFull=1, 5th request stalls. Raising DrainEn → 5th granted one cycle after the first pop; RxCount reaches 5.
- DrainPeriod=4 with a continuously full FIFO → RxValid pulses exactly every 4 cycles.
- Packet with xDst/yDst=8'h12 → RxError=1 on its RxValid, ErrCount=1, RxCount increments.
- reset pulsed during ACK with 2 entries queued → next edge: all outputs 0, FifoLevel=0, UpStrFull=0. The next request is granted normally.

Source files
------------

// File: rtl/packet_ejector_pkg.sv
// Shared definitions for the packet ejector: packet field layout and accept-FSM encodings.
package packet_ejector_pkg;

   // xDst 31:28 | yDst 27:24 | xSrc 23:20 | ySrc 19:16 | PacketID 15:6 | ModuleID 5:0
   typedef struct packed {
      logic [3:0] x_dst;
      logic [3:0] y_dst;
      logic [3:0] x_src;
      logic [3:0] y_src;
      logic [9:0] packet_id;
      logic [5:0] module_id;
   } packet_t;

   localparam int DST_MSB = 31;
   localparam int DST_LSB = 24;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ACK     = 2'b01,
      ST_RELEASE = 2'b10
   } acc_state_e;

endpackage

// File: rtl/ejector_fifo.sv
// Synchronous receive FIFO with registered level and full flag.
module ejector_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wr_data,
   input  logic                     pop,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && !full_q;
      do_pop   = pop && (level_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q + LW'(do_push) - LW'(do_pop);
      full_d   = (level_d == LW'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;
   assign full    = full_q;
   assign empty   = (level_q == '0);
endmodule

// File: rtl/packet_ejector.sv
// Router Local-port sink: accept FSM into a FIFO, rate-limited drain with destination check.
//   state      | meaning
//   ST_IDLE    | waiting for a request while the FIFO has room
//   ST_ACK     | grant pulse out, packet already pushed
//   ST_RELEASE | waiting for the router to drop its stale request
module packet_ejector
   import packet_ejector_pkg::*;
#(
   parameter logic [5:0] routerID    = 6'b000_000,
   parameter int         dataWidth   = 32,
   parameter int         dim         = 4,
   parameter int         FifoDepth   = 4,
   parameter int         DrainPeriod = 1,
   parameter logic [7:0] ExpectDst   = 8'b1001_0010
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ReqUpStr,
   output logic                          GntUpStr,
   output logic                          UpStrFull,
   input  logic [dataWidth-1:0]          PacketIn,
   input  logic                          DrainEn,
   output logic                          RxValid,
   output logic [dataWidth-1:0]          RxPacket,
   output logic                          RxError,
   output logic [15:0]                   RxCount,
   output logic [15:0]                   ErrCount,
   output logic [$clog2(FifoDepth):0]    FifoLevel
);
   localparam int             TW   = (DrainPeriod > 1) ? $clog2(DrainPeriod) : 1;
   localparam logic [TW-1:0]  TMAX = TW'(DrainPeriod - 1);

   acc_state_e           state_q, state_d;
   logic                 gnt_q, gnt_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 rx_valid_q, rx_valid_d;
   logic [dataWidth-1:0] rx_packet_q, rx_packet_d;
   logic                 rx_error_q, rx_error_d;
   logic [15:0]          rx_count_q, rx_count_d;
   logic [15:0]          err_count_q, err_count_d;

   logic                 push, pop;
   logic                 fifo_full, fifo_empty;
   logic [dataWidth-1:0] fifo_head;

   logic unused_cfg;
   assign unused_cfg = ^{routerID, dim[0]};

   ejector_fifo #(.W(dataWidth), .DEPTH(FifoDepth)) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push    (push),
      .wr_data (PacketIn),
      .pop     (pop),
      .rd_data (fifo_head),
      .level   (FifoLevel),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Full is judged on the registered flag, so a same-cycle pop never frees a slot early.
   always_comb begin
      state_d = state_q;
      gnt_d   = 1'b0;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ReqUpStr && !fifo_full) begin
               push    = 1'b1;
               gnt_d   = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK:     state_d = ReqUpStr ? ST_RELEASE : ST_IDLE;
         ST_RELEASE: if (!ReqUpStr) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pop         = (timer_q == TMAX) && DrainEn && !fifo_empty;
      timer_d     = pop ? '0 : ((timer_q == TMAX) ? timer_q : timer_q + 1'b1);
      rx_valid_d  = pop;
      rx_error_d  = pop && (fifo_head[DST_MSB:DST_LSB] != ExpectDst);
      rx_packet_d = pop ? fifo_head : rx_packet_q;
      rx_count_d  = rx_count_q + 16'(pop);
      err_count_d = err_count_q + 16'(rx_error_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= 1'b0;
         timer_q     <= '0;
         rx_valid_q  <= 1'b0;
         rx_packet_q <= '0;
         rx_error_q  <= 1'b0;
         rx_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         timer_q     <= timer_d;
         rx_valid_q  <= rx_valid_d;
         rx_packet_q <= rx_packet_d;
         rx_error_q  <= rx_error_d;
         rx_count_q  <= rx_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign GntUpStr  = gnt_q;
   assign UpStrFull = fifo_full;
   assign RxValid   = rx_valid_q;
   assign RxPacket  = rx_packet_q;
   assign RxError   = rx_error_q;
   assign RxCount   = rx_count_q;
   assign ErrCount  = err_count_q;
endmodule

// File: tb/tb_packet_ejector.sv
// Directed bench for packet_ejector: handshake, backpressure, drain rate, dst check, reset.
module tb_packet_ejector;
   import packet_ejector_pkg::*;

   logic        clk;
   logic        reset;

   logic        req, drain_en, gnt, full, rxv, rxe;
   logic [31:0] pkt, rxp;
   logic [15:0] rxc, errc;
   logic [2:0]  lvl;

   logic        req4, drain4, gnt4, full4, rxv4, rxe4;
   logic [31:0] pkt4, rxp4;
   logic [15:0] rxc4, errc4;
   logic [2:0]  lvl4;

   int n_checks = 0;
   int n_errors = 0;
   int n;
   bit got;

   packet_ejector #(.FifoDepth(4), .DrainPeriod(1)) dut (
      .clk(clk), .reset(reset), .ReqUpStr(req), .GntUpStr(gnt), .UpStrFull(full),
      .PacketIn(pkt), .DrainEn(drain_en), .RxValid(rxv), .RxPacket(rxp), .RxError(rxe),
      .RxCount(rxc), .ErrCount(errc), .FifoLevel(lvl)
   );

   packet_ejector #(.FifoDepth(4), .DrainPeriod(4)) dut4 (
      .clk(clk), .reset(reset), .ReqUpStr(req4), .GntUpStr(gnt4), .UpStrFull(full4),
      .PacketIn(pkt4), .DrainEn(drain4), .RxValid(rxv4), .RxPacket(rxp4), .RxError(rxe4),
      .RxCount(rxc4), .ErrCount(errc4), .FifoLevel(lvl4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got_v, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise the request, wait (bounded) for the grant, then drop the request.
   task automatic send(input logic [31:0] p, output int waited);
      bit seen;
      seen   = 1'b0;
      waited = 0;
      req    = 1'b1;
      pkt    = p;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         waited++;
         if (gnt) seen = 1'b1;
      end
      req = 1'b0;
      if (!seen) waited = -1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"},  32'(gnt),  32'd0);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_rxv"},  32'(rxv),  32'd0);
      chk({tag, "_rxp"},  rxp,       32'd0);
      chk({tag, "_rxe"},  32'(rxe),  32'd0);
      chk({tag, "_rxc"},  32'(rxc),  32'd0);
      chk({tag, "_errc"}, 32'(errc), 32'd0);
      chk({tag, "_lvl"},  32'(lvl),  32'd0);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; pkt = '0; drain_en = 1'b0;
      req4 = 1'b0; pkt4 = '0; drain4 = 1'b0;
      repeat (2) tick();
      chk_reset_outputs("rst");
      reset = 1'b0;
      tick();

      // Single good packet, immediate drain
      drain_en = 1'b1;
      send(32'h9200_0045, n);
      chk("t1_gnt_latency", 32'(n), 32'd1);
      chk("t1_lvl", 32'(lvl), 32'd1);
      tick();
      chk("t1_gnt_off", 32'(gnt), 32'd0);
      chk("t1_rxv", 32'(rxv), 32'd1);
      chk("t1_rxp", rxp, 32'h9200_0045);
      chk("t1_rxe", 32'(rxe), 32'd0);
      chk("t1_rxc", 32'(rxc), 32'd1);
      chk("t1_lvl0", 32'(lvl), 32'd0);
      tick();
      chk("t1_rxv_off", 32'(rxv), 32'd0);

      // Held request: one push only, FSM parks in RELEASE
      drain_en = 1'b0;
      req = 1'b1; pkt = 32'h9200_0002;
      tick();
      chk("t2_gnt", 32'(gnt), 32'd1);
      chk("t2_lvl_a", 32'(lvl), 32'd1);
      tick();
      chk("t2_gnt_off", 32'(gnt), 32'd0);
      chk("t2_state_rel", 32'(dut.state_q), 32'(ST_RELEASE));
      tick();
      chk("t2_state_rel2", 32'(dut.state_q), 32'(ST_RELEASE));
      chk("t2_lvl_b", 32'(lvl), 32'd1);
      req = 1'b0;
      tick();
      chk("t2_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
      chk("t2_lvl_c", 32'(lvl), 32'd1);
      drain_en = 1'b1;
      tick();
      chk("t2_rxv", 32'(rxv), 32'd1);
      chk("t2_rxp", rxp, 32'h9200_0002);
      chk("t2_rxc", 32'(rxc), 32'd2);
      chk("t2_lvl0", 32'(lvl), 32'd0);
      drain_en = 1'b0;

      // Backpressure: fill 4, 5th stalls until the first pop
      for (int i = 1; i <= 4; i++) begin
         send(32'h9211_0000 + 32'(i), n);
         chk("t3_gnt_latency", 32'(n), 32'd1);
         chk("t3_lvl", 32'(lvl), 32'(i));
         chk("t3_full", 32'(full), (i == 4) ? 32'd1 : 32'd0);
         tick();
      end
      req = 1'b1; pkt = 32'h9211_0005;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_stall_gnt", 32'(gnt), 32'd0);
      end
      chk("t3_lvl_full", 32'(lvl), 32'd4);
      drain_en = 1'b1;
      tick();
      chk("t3_pop_rxv", 32'(rxv), 32'd1);
      chk("t3_pop_gnt", 32'(gnt), 32'd0);
      chk("t3_pop_full", 32'(full), 32'd0);
      chk("t3_pop_lvl", 32'(lvl), 32'd3);
      chk("t3_pop_rxp", rxp, 32'h9211_0001);
      tick();
      chk("t3_5th_gnt", 32'(gnt), 32'd1);
      chk("t3_5th_lvl", 32'(lvl), 32'd3);
      chk("t3_5th_rxp", rxp, 32'h9211_0002);
      req = 1'b0;
      repeat (3) tick();
      chk("t3_end_lvl", 32'(lvl), 32'd0);
      chk("t3_end_rxc", 32'(rxc), 32'd7);
      chk("t3_end_rxp", rxp, 32'h9211_0005);

      // Misrouted packet
      send(32'h1234_5678, n);
      chk("t5_gnt_latency", 32'(n), 32'd1);
      tick();
      chk("t5_rxv", 32'(rxv), 32'd1);
      chk("t5_rxe", 32'(rxe), 32'd1);
      chk("t5_errc", 32'(errc), 32'd1);
      chk("t5_rxc", 32'(rxc), 32'd8);
      chk("t5_rxp", rxp, 32'h1234_5678);

      // DrainPeriod=4 instance: pops every 4 cycles from a full FIFO
      for (int p = 1; p <= 4; p++) begin
         req4 = 1'b1; pkt4 = 32'h9200_0100 + 32'(p);
         got  = 1'b0;
         for (int j = 0; j < 10 && !got; j++) begin
            tick();
            if (gnt4) got = 1'b1;
         end
         chk("t4_grant", 32'(got), 32'd1);
         req4 = 1'b0;
         tick();
      end
      chk("t4_full", 32'(full4), 32'd1);
      chk("t4_lvl", 32'(lvl4), 32'd4);
      drain4 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("t4_rxv", 32'(rxv4), (((i - 1) % 4) == 0) ? 32'd1 : 32'd0);
      end
      chk("t4_rxc", 32'(rxc4), 32'd4);
      chk("t4_lvl0", 32'(lvl4), 32'd0);
      drain4 = 1'b0;

      // Reset during ACK with two entries queued
      drain_en = 1'b0;
      send(32'h9200_0201, n);
      chk("t6_gnt_a", 32'(n), 32'd1);
      tick();
      send(32'h9200_0202, n);
      chk("t6_gnt_b", 32'(n), 32'd1);
      chk("t6_lvl2", 32'(lvl), 32'd2);
      reset = 1'b1;
      tick();
      chk_reset_outputs("t6_rst");
      reset = 1'b0;
      drain_en = 1'b1;
      tick();
      send(32'h9200_00AA, n);
      chk("t6_regrant", 32'(n), 32'd1);
      tick();
      chk("t6_rxv", 32'(rxv), 32'd1);
      chk("t6_rxp", rxp, 32'h9200_00AA);
      chk("t6_rxc", 32'(rxc), 32'd1);
      chk("t6_errc", 32'(errc), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
